sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//  Downstream stage of the 2-bit combinational operand adder: consumes its sum y as a
//  packetised stream and accumulates one packet into a wide register. The total is
//  presented on a registered valid/ready output once the last beat is taken. Gives the
//  adder path a real sequential consumer for synthesis/elaboration regression.
// PARAMETERS
//  DATA_W   2  width of incoming sum (matches adder output y)
//  ACC_W    8  accumulator width; must be >= DATA_W+1
//  CNT_W    6  beat-counter width
//  SATURATE 1  1: accumulator/counter clamp at all-ones; 0: wrap modulo 2**W
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       in_sum/in_last valid
//  in_ready   out  1       stage can accept a beat
//  in_sum     in   DATA_W  adder result y, unsigned
//  in_last    in   1       final beat of packet
//  out_valid  out  1       packet result valid
//  out_ready  in   1       consumer takes result
//  out_acc    out  ACC_W   packet sum
//  out_count  out  CNT_W   beats in packet
//  out_ovf    out  1       accumulator or counter clamped/wrapped during packet
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0,
//    out_acc=0, out_count=0, out_ovf=0, internal acc/cnt/ovf=0.
//  - Accept = in_valid & in_ready; Release = out_valid & out_ready.
//  - States: IDLE, ACCUM, DRAIN. in_ready = (state != DRAIN), combinational from state.
//  - IDLE + accept: acc=zext(in_sum), cnt=1, ovf=0; in_last ? DRAIN : ACCUM.
//  - ACCUM + accept: acc=acc+zext(in_sum), cnt=cnt+1 (clamp/wrap per SATURATE);
//    ovf|=carry-out of either add; in_last ? DRAIN : ACCUM. No accept: hold.
//  - Entering DRAIN: out_acc/out_count/out_ovf load the post-update values in the same
//    edge; out_valid=1 the cycle after the last beat is accepted (latency 1).
//  - DRAIN: outputs stable while out_valid & !out_ready. Release -> IDLE, out_valid=0
//    next cycle; out_acc/out_count/out_ovf retain last values (not cleared).
//  - No overlap: in_ready=0 throughout DRAIN incl. release cycle; first beat of next
//    packet is accepted earliest one cycle after release.
//  - Single-beat packet (in_last on first beat) legal: IDLE -> DRAIN directly.
//  - SATURATE=1: acc clamps at 2**ACC_W-1, cnt at 2**CNT_W-1, ovf=1, remain clamped.
//    SATURATE=0: wrap modulo, ovf=1 on any wrap.
//  - in_valid while !in_ready: ignored, no state change; in_sum/in_last not sampled.
//  - rst_n low mid-packet or in DRAIN: immediate return to reset values; partial
//    packet discarded, no output produced.
//  - in_sum X while in_valid=0 must not propagate into registers.
// STRUCTURE
//  - Package sum_acc_pkg: typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} acc_state_t;
//    localparams for reset values; nothing width-specific beyond the enum.
//  - Sub-module sum_acc_sat_add #(W, SATURATE): a+b -> {sum, ovf}; instantiated twice
//    (accumulator, counter). Top holds FSM, handshake and output registers.
// TESTING
//  1 Reset: rst_n=0 -> in_ready=1, out_valid=0, out_acc=0, out_count=0, out_ovf=0.
//  2 Packet sums 3,2,1(last), out_ready=1 -> out_valid 1 cycle after last accept,
//    out_acc=6, out_count=3, out_ovf=0; next cycle out_valid=0, in_ready=1.
//  3 Single beat sum=2 with last, out_ready=0 for 4 cycles -> out_valid held, out_acc=2,
//    out_count=1 stable, in_ready=0 until cycle after release.
//  4 ACC_W=4,SATURATE=1: six beats of 3 -> out_acc=15, out_ovf=1; SATURATE=0 same
//    stimulus -> out_acc=2 (18 mod 16), out_ovf=1.
//  5 in_valid toggled randomly, in_valid during DRAIN with sum=3 -> ignored; totals match
//    scoreboard of accepted beats only.
//  6 rst_n pulsed low after 2 beats of packet -> no out_valid; next packet 1,1(last)
//    -> out_acc=2, out_count=2.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared state encoding and reset values for the sum accumulator
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_t;

  localparam acc_state_t RESET_STATE = IDLE;
  localparam logic       RESET_VALID = 1'b0;
  localparam logic       RESET_OVF   = 1'b0;

endpackage

// File: rtl/sum_acc_sat_add.sv
// rtl/sum_acc_sat_add.sv - unsigned W-bit add with carry-out flag and optional clamp to all-ones
module sum_acc_sat_add #(
  parameter int W        = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};

  always_comb begin
    ovf = raw[W];
    if (SATURATE && raw[W]) begin
      sum = '1;
    end else begin
      sum = raw[W-1:0];
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates one packet of adder sums and presents the total on a
// registered valid/ready output
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W   = 2,
  parameter int ACC_W    = 8,
  parameter int CNT_W    = 6,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  acc_state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum, in_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
  logic             ovf_q, ovf_d, acc_ovf, cnt_ovf;
  logic             accept, rel, finish;

  assign accept = in_valid & in_ready;
  assign rel    = out_valid & out_ready;
  assign finish = accept & in_last;

  // Gate the operand so an unqualified in_sum never reaches the adder or registers
  assign in_ext = accept ? {{(ACC_W-DATA_W){1'b0}}, in_sum} : '0;

  sum_acc_sat_add #(.W(ACC_W), .SATURATE(SATURATE)) u_acc_add (
    .a   (acc_q),
    .b   (in_ext),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  sum_acc_sat_add #(.W(CNT_W), .SATURATE(SATURATE)) u_cnt_add (
    .a   (cnt_q),
    .b   (CNT_W'(1)),
    .sum (cnt_sum),
    .ovf (cnt_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (accept) state_d = in_last ? DRAIN : ACCUM;
      DRAIN:       if (rel) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q != DRAIN);
  end

  // The first beat of a packet restarts the running totals instead of adding to them
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      if (state_q == IDLE) begin
        acc_d = in_ext;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_sum;
        ovf_d = ovf_q | acc_ovf | cnt_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= RESET_OVF;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Result registers keep their last packet after release; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= RESET_VALID;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= RESET_OVF;
    end else begin
      if (finish) begin
        out_valid <= 1'b1;
        out_acc   <= acc_d;
        out_count <= cnt_d;
        out_ovf   <= ovf_d;
      end else if (rel) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - checks sum_accumulator (8-bit saturating, 4-bit saturating and
// 4-bit wrapping instances on shared stimulus) against a packet-level model
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_sum;
  logic       in_last;
  logic       out_ready;

  logic       rdy8, rdy_s4, rdy_w4;
  logic       vld8, vld_s4, vld_w4;
  logic [7:0] acc8;
  logic [3:0] acc_s4, acc_w4;
  logic [5:0] cnt8, cnt_s4, cnt_w4;
  logic       ovf8, ovf_s4, ovf_w4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.DATA_W(2), .ACC_W(8), .CNT_W(6), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_sum(in_sum),
    .in_last(in_last), .out_valid(vld8), .out_ready(out_ready), .out_acc(acc8),
    .out_count(cnt8), .out_ovf(ovf8));

  sum_accumulator #(.DATA_W(2), .ACC_W(4), .CNT_W(6), .SATURATE(1'b1)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s4), .in_sum(in_sum),
    .in_last(in_last), .out_valid(vld_s4), .out_ready(out_ready), .out_acc(acc_s4),
    .out_count(cnt_s4), .out_ovf(ovf_s4));

  sum_accumulator #(.DATA_W(2), .ACC_W(4), .CNT_W(6), .SATURATE(1'b0)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w4), .in_sum(in_sum),
    .in_last(in_last), .out_valid(vld_w4), .out_ready(out_ready), .out_acc(acc_w4),
    .out_count(cnt_w4), .out_ovf(ovf_w4));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_acc(input int total, input int w, input bit sat);
    int lim;
    lim = (1 << w) - 1;
    if (sat) return (total > lim) ? lim : total;
    return total % (1 << w);
  endfunction

  function automatic int exp_ovf(input int total, input int n, input int w);
    return ((total > (1 << w) - 1) || (n > 63)) ? 1 : 0;
  endfunction

  // Packet-level model: running total and beat count of accepted beats only
  bit m_drain, m_inpkt;
  int m_sum, m_n;
  int e_acc8, e_cnt8, e_ovf8, e_acc_s4, e_cnt_s4, e_ovf_s4, e_acc_w4, e_cnt_w4, e_ovf_w4;
  int tot_next, n_next;

  assign tot_next = (m_inpkt ? m_sum : 0) + int'(in_sum);
  assign n_next   = (m_inpkt ? m_n : 0) + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_drain <= 1'b0; m_inpkt <= 1'b0; m_sum <= 0; m_n <= 0;
      e_acc8 <= 0; e_cnt8 <= 0; e_ovf8 <= 0;
      e_acc_s4 <= 0; e_cnt_s4 <= 0; e_ovf_s4 <= 0;
      e_acc_w4 <= 0; e_cnt_w4 <= 0; e_ovf_w4 <= 0;
    end else if (m_drain) begin
      if (out_ready) m_drain <= 1'b0;
    end else if (in_valid) begin
      m_sum <= tot_next;
      m_n   <= n_next;
      if (in_last) begin
        m_drain  <= 1'b1;
        m_inpkt  <= 1'b0;
        e_acc8   <= exp_acc(tot_next, 8, 1'b1);
        e_cnt8   <= (n_next > 63) ? 63 : n_next;
        e_ovf8   <= exp_ovf(tot_next, n_next, 8);
        e_acc_s4 <= exp_acc(tot_next, 4, 1'b1);
        e_cnt_s4 <= (n_next > 63) ? 63 : n_next;
        e_ovf_s4 <= exp_ovf(tot_next, n_next, 4);
        e_acc_w4 <= exp_acc(tot_next, 4, 1'b0);
        e_cnt_w4 <= n_next % 64;
        e_ovf_w4 <= exp_ovf(tot_next, n_next, 4);
      end else begin
        m_inpkt <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready8", int'(rdy8), int'(!m_drain));
    check("in_ready_s4", int'(rdy_s4), int'(!m_drain));
    check("in_ready_w4", int'(rdy_w4), int'(!m_drain));
    check("out_valid8", int'(vld8), int'(m_drain));
    check("out_valid_s4", int'(vld_s4), int'(m_drain));
    check("out_valid_w4", int'(vld_w4), int'(m_drain));
    check("out_acc8", int'(acc8), e_acc8);
    check("out_count8", int'(cnt8), e_cnt8);
    check("out_ovf8", int'(ovf8), e_ovf8);
    check("out_acc_s4", int'(acc_s4), e_acc_s4);
    check("out_count_s4", int'(cnt_s4), e_cnt_s4);
    check("out_ovf_s4", int'(ovf_s4), e_ovf_s4);
    check("out_acc_w4", int'(acc_w4), e_acc_w4);
    check("out_count_w4", int'(cnt_w4), e_cnt_w4);
    check("out_ovf_w4", int'(ovf_w4), e_ovf_w4);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] s, input logic l);
    int  budget;
    bit  took;
    budget = 0;
    took = 1'b0;
    in_valid = 1'b1; in_sum = s; in_last = l;
    while (!took && budget < 20) begin
      @(negedge clk);
      took = rdy8;
      tick();
      budget++;
    end
    if (!took) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_accept: got in_ready=0 for 20 cycles expected acceptance at %0t", $time);
    end
    in_valid = 1'b0; in_sum = 2'bxx; in_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = 2'b00; in_last = 1'b0; out_ready = 1'b0;

    // 1: reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(rdy8), 1);
    check("rst_out_valid", int'(vld8), 0);
    check("rst_out_acc", int'(acc8), 0);
    check("rst_out_count", int'(cnt8), 0);
    check("rst_out_ovf", int'(ovf8), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: 3,2,1(last) with consumer ready
    out_ready = 1'b1;
    beat(2'd3, 1'b0); beat(2'd2, 1'b0); beat(2'd1, 1'b1);
    @(negedge clk);
    check("t2_out_valid", int'(vld8), 1);
    check("t2_out_acc", int'(acc8), 6);
    check("t2_out_count", int'(cnt8), 3);
    check("t2_out_ovf", int'(ovf8), 0);
    tick();
    @(negedge clk);
    check("t2_out_valid_drop", int'(vld8), 0);
    check("t2_in_ready_back", int'(rdy8), 1);
    tick();

    // 3: single beat held by back-pressure
    out_ready = 1'b0;
    beat(2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_out_valid_hold", int'(vld8), 1);
      check("t3_out_acc", int'(acc8), 2);
      check("t3_out_count", int'(cnt8), 1);
      check("t3_in_ready_low", int'(rdy8), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t3_released", int'(vld8), 0);
    check("t3_in_ready", int'(rdy8), 1);
    check("t3_acc_retained", int'(acc8), 2);
    tick();

    // 4: six beats of 3 -> 18
    for (int i = 0; i < 6; i++) beat(2'd3, (i == 5));
    @(negedge clk);
    check("t4_sat_acc", int'(acc_s4), 15);
    check("t4_sat_ovf", int'(ovf_s4), 1);
    check("t4_wrap_acc", int'(acc_w4), 2);
    check("t4_wrap_ovf", int'(ovf_w4), 1);
    check("t4_wide_acc", int'(acc8), 18);
    check("t4_wide_ovf", int'(ovf8), 0);
    tick();
    tick();

    // Counter boundary: 70 beats of 3
    for (int i = 0; i < 70; i++) beat(2'd3, (i == 69));
    @(negedge clk);
    check("cnt_sat_acc", int'(acc8), 210);
    check("cnt_sat_count", int'(cnt8), 63);
    check("cnt_sat_ovf", int'(ovf8), 1);
    check("cnt_wrap_count", int'(cnt_w4), 6);
    tick();
    tick();

    // 5a: in_valid with sum=3 during DRAIN is ignored
    out_ready = 1'b0;
    beat(2'd1, 1'b0); beat(2'd2, 1'b1);
    in_valid = 1'b1; in_sum = 2'd3; in_last = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    check("t5_drain_acc", int'(acc8), 3);
    check("t5_drain_count", int'(cnt8), 2);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();

    // 5b: random valid/ready traffic checked by the model
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_sum    = 2'($urandom_range(0, 3));
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();

    // 6: reset mid-packet discards it
    beat(2'd1, 1'b0); beat(2'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_no_valid", int'(vld8), 0);
    check("t6_acc_cleared", int'(acc8), 0);
    check("t6_in_ready", int'(rdy8), 1);
    tick();
    rst_n = 1'b1;
    tick();
    beat(2'd1, 1'b0); beat(2'd1, 1'b1);
    @(negedge clk);
    check("t6_out_valid", int'(vld8), 1);
    check("t6_out_acc", int'(acc8), 2);
    check("t6_out_count", int'(cnt8), 2);
    tick();
    tick();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
